// File: rtl/sdr_sched_pkg.sv
// Shared constants and types for the closed-page SDRAM command scheduler.
package sdr_sched_pkg;

    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned BA_W       = 2;
    localparam int unsigned SDR_ADDR_W = 13;

    localparam int unsigned BANK_HI = 24;
    localparam int unsigned BANK_LO = 23;
    localparam int unsigned ROW_HI  = 22;
    localparam int unsigned ROW_LO  = 10;
    localparam int unsigned COL_HI  = 9;
    localparam int unsigned COL_LO  = 0;

    // {cs_n, ras_n, cas_n, we_n}, same values as the sdr_bus command enum
    localparam logic [3:0] CMD_DESEL   = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_IDLE,
        ST_RCD_WAIT,
        ST_XFER,
        ST_DAL_WAIT,
        ST_REF_WAIT
    } sched_state_e;

    typedef struct packed {
        logic                  wr;
        logic                  port;
        logic [BA_W-1:0]       bank;
        logic [COL_HI:COL_LO]  col;
    } xfer_t;

    // Column address with A10 set so every access auto-precharges.
    function automatic logic [SDR_ADDR_W-1:0] col_addr(input logic [COL_HI:COL_LO] col);
        return {2'b00, 1'b1, col};
    endfunction

endpackage

// File: rtl/sdr_cmd_sched_if.sv
// Client request ports and SDRAM command pins of the scheduler.
interface sdr_cmd_sched_if;
    import sdr_sched_pkg::*;

    logic [1:0]            req_valid;
    logic [1:0]            req_wr;
    logic [ADDR_W-1:0]     req_addr0;
    logic [ADDR_W-1:0]     req_addr1;
    logic [1:0]            req_ack;
    logic                  col_rd;
    logic                  col_wr;
    logic                  col_port;
    logic                  sdr_cs_n;
    logic                  sdr_ras_n;
    logic                  sdr_cas_n;
    logic                  sdr_we_n;
    logic [BA_W-1:0]       sdr_ba;
    logic [SDR_ADDR_W-1:0] sdr_addr;
    logic                  ref_overrun;

    modport master (
        output req_valid, req_wr, req_addr0, req_addr1,
        input  req_ack, col_rd, col_wr, col_port,
        input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr, ref_overrun
    );

    modport slave (
        input  req_valid, req_wr, req_addr0, req_addr1,
        output req_ack, col_rd, col_wr, col_port,
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr, ref_overrun
    );

endinterface

// File: rtl/sdr_refresh_timer.sv
// Refresh interval down-counter with pending and sticky overrun flags.
module sdr_refresh_timer #(
    parameter int unsigned TREF_CYC = 780
) (
    input  logic sdram_clk,
    input  logic sdram_reset,
    input  logic hold,
    input  logic clear_pending,
    output logic pending,
    output logic overrun
);

    localparam int unsigned CNT_W = ($clog2(TREF_CYC) > 0) ? $clog2(TREF_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TREF_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic             expire_c;

    assign expire_c = !hold && (cnt == '0);

    // A clear landing on the expiry cycle loses to the new expiry, so no refresh is dropped.
    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            cnt     <= RELOAD;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (hold || expire_c) cnt <= RELOAD;
            else                  cnt <= cnt - CNT_W'(1);

            if (expire_c)           pending <= 1'b1;
            else if (clear_pending) pending <= 1'b0;

            if (expire_c && pending && !clear_pending) overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/sdr_cmd_sched.sv
// Closed-page SDRAM command scheduler: round-robin over two clients, ACTIVE then
// READ/WRITE with auto-precharge, periodic AUTO REFRESH.
module sdr_cmd_sched
    import sdr_sched_pkg::*;
#(
    parameter int unsigned TRCD     = 2,
    parameter int unsigned TDAL     = 4,
    parameter int unsigned TRFC     = 7,
    parameter int unsigned TREF_CYC = 780
) (
    input  logic            sdram_clk,
    input  logic            sdram_reset,
    input  logic            sdr_init_done,
    sdr_cmd_sched_if.slave  bus
);

    localparam int unsigned WAIT_MAX = (TRCD > TDAL) ? ((TRCD > TRFC) ? TRCD : TRFC)
                                                     : ((TDAL > TRFC) ? TDAL : TRFC);
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] RCD_LOAD = WAIT_W'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [WAIT_W-1:0] DAL_LOAD = WAIT_W'(TDAL - 1);
    localparam logic [WAIT_W-1:0] RFC_LOAD = WAIT_W'(TRFC - 1);

    sched_state_e      state;
    logic [WAIT_W-1:0] wait_cnt;
    xfer_t             cur;
    logic              rr_ptr;
    logic [3:0]        cmd_q;

    logic              ref_pending;
    logic              ref_hold_c;
    logic              ref_clear_c;
    logic              any_req_c;
    logic              grant_c;
    logic [ADDR_W-1:0] sel_addr_c;

    assign {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = cmd_q;

    assign ref_hold_c  = (state == ST_INIT_WAIT);
    assign ref_clear_c = (state == ST_IDLE) && ref_pending;

    // Under contention the port that did not win last time is granted.
    always_comb begin
        any_req_c = |bus.req_valid;
        if (&bus.req_valid) grant_c = ~rr_ptr;
        else                grant_c = bus.req_valid[1];
        sel_addr_c = grant_c ? bus.req_addr1 : bus.req_addr0;
    end

    sdr_refresh_timer #(.TREF_CYC(TREF_CYC)) u_refresh_timer (
        .sdram_clk     (sdram_clk),
        .sdram_reset   (sdram_reset),
        .hold          (ref_hold_c),
        .clear_pending (ref_clear_c),
        .pending       (ref_pending),
        .overrun       (bus.ref_overrun)
    );

    // Sequencer; one shared wait counter serves tRCD, tDAL and tRFC.
    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            state        <= ST_INIT_WAIT;
            wait_cnt     <= '0;
            cur          <= '0;
            rr_ptr       <= 1'b1;
            cmd_q        <= CMD_DESEL;
            bus.sdr_ba   <= '0;
            bus.sdr_addr <= '0;
            bus.req_ack  <= '0;
            bus.col_rd   <= 1'b0;
            bus.col_wr   <= 1'b0;
            bus.col_port <= 1'b0;
        end else begin
            cmd_q       <= CMD_NOP;
            bus.req_ack <= '0;
            bus.col_rd  <= 1'b0;
            bus.col_wr  <= 1'b0;
            case (state)
                ST_INIT_WAIT: begin
                    cmd_q <= CMD_DESEL;
                    if (sdr_init_done) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (ref_pending) begin
                        cmd_q    <= CMD_REFRESH;
                        wait_cnt <= RFC_LOAD;
                        state    <= ST_REF_WAIT;
                    end else if (any_req_c) begin
                        rr_ptr       <= grant_c;
                        cur.wr       <= bus.req_wr[grant_c];
                        cur.port     <= grant_c;
                        cur.bank     <= sel_addr_c[BANK_HI:BANK_LO];
                        cur.col      <= sel_addr_c[COL_HI:COL_LO];
                        cmd_q        <= CMD_ACTIVE;
                        bus.sdr_ba   <= sel_addr_c[BANK_HI:BANK_LO];
                        bus.sdr_addr <= sel_addr_c[ROW_HI:ROW_LO];
                        bus.req_ack  <= grant_c ? 2'b10 : 2'b01;
                        wait_cnt     <= RCD_LOAD;
                        state        <= (TRCD > 1) ? ST_RCD_WAIT : ST_XFER;
                    end
                end
                ST_RCD_WAIT: begin
                    if (wait_cnt == '0) state    <= ST_XFER;
                    else                wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                ST_XFER: begin
                    cmd_q        <= cur.wr ? CMD_WRITE : CMD_READ;
                    bus.sdr_ba   <= cur.bank;
                    bus.sdr_addr <= col_addr(cur.col);
                    bus.col_rd   <= ~cur.wr;
                    bus.col_wr   <= cur.wr;
                    bus.col_port <= cur.port;
                    wait_cnt     <= DAL_LOAD;
                    state        <= ST_DAL_WAIT;
                end
                ST_DAL_WAIT, ST_REF_WAIT: begin
                    if (wait_cnt == '0) state    <= ST_IDLE;
                    else                wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_cmd_sched.sv
// Bench for sdr_cmd_sched: command-queue reference model checked every cycle,
// directed literal scenarios, randomized traffic, and a short-interval overrun instance.
module tb_sdr_cmd_sched;

    localparam int TRCD = 2;
    localparam int TDAL = 4;
    localparam int TRFC = 7;
    localparam int TREF = 20;

    localparam logic [3:0] P_DESEL = 4'b1111;
    localparam logic [3:0] P_NOP   = 4'b0111;
    localparam logic [3:0] P_ACT   = 4'b0011;
    localparam logic [3:0] P_RD    = 4'b0101;
    localparam logic [3:0] P_WR    = 4'b0100;
    localparam logic [3:0] P_REF   = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, init_done, rst2, init2;
    sdr_cmd_sched_if bus ();
    sdr_cmd_sched_if bus2 ();

    sdr_cmd_sched #(.TRCD(TRCD), .TDAL(TDAL), .TRFC(TRFC), .TREF_CYC(TREF)) dut (
        .sdram_clk(clk), .sdram_reset(rst), .sdr_init_done(init_done), .bus(bus));

    sdr_cmd_sched #(.TRCD(TRCD), .TDAL(TDAL), .TRFC(TRFC), .TREF_CYC(3)) dut_ovr (
        .sdram_clk(clk), .sdram_reset(rst2), .sdr_init_done(init2), .bus(bus2));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit done2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] pins1();
        return {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
    endfunction

    function automatic logic [3:0] pins2();
        return {bus2.sdr_cs_n, bus2.sdr_ras_n, bus2.sdr_cas_n, bus2.sdr_we_n};
    endfunction

    // ---------------- reference model: per-edge expected outputs from a command queue
    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [1:0]  ack;
        logic        rd;
        logic        wr;
        logic        port;
        bit          has_addr;
        bit          chk_port;
    } exp_t;

    function automatic exp_t mk(input logic [3:0] c);
        exp_t e;
        e.cmd = c; e.ba = '0; e.addr = '0; e.ack = '0; e.rd = 1'b0; e.wr = 1'b0;
        e.port = 1'b0; e.has_addr = 0; e.chk_port = 0;
        return e;
    endfunction

    exp_t        m_q[$];
    exp_t        m_exp;
    exp_t        me;
    bit          m_live = 0;
    bit          m_init, m_pend, m_ovr, m_rr, mp;
    int          m_k;
    logic [24:0] ma;
    logic        mw;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_live = 1; m_init = 1; m_k = 0; m_pend = 0; m_ovr = 0; m_rr = 1;
            m_q.delete();
            m_exp = mk(P_DESEL);
            m_exp.has_addr = 1;
            m_exp.chk_port = 1;
        end else if (m_live) begin
            if (m_init) begin
                m_exp = mk(P_DESEL);
                if (init_done) m_init = 0;
            end else begin
                if (m_q.size() == 0) begin
                    if (m_pend) begin
                        m_pend = 0;
                        m_q.push_back(mk(P_REF));
                        for (int i = 0; i < TRFC; i++) m_q.push_back(mk(P_NOP));
                    end else if (bus.req_valid != 2'b00) begin
                        mp = (bus.req_valid == 2'b11) ? !m_rr : bus.req_valid[1];
                        m_rr = mp;
                        ma = mp ? bus.req_addr1 : bus.req_addr0;
                        mw = bus.req_wr[mp];
                        me = mk(P_ACT);
                        me.has_addr = 1; me.ba = ma[24:23]; me.addr = ma[22:10];
                        me.ack = mp ? 2'b10 : 2'b01;
                        m_q.push_back(me);
                        for (int i = 0; i < TRCD - 1; i++) m_q.push_back(mk(P_NOP));
                        me = mk(mw ? P_WR : P_RD);
                        me.has_addr = 1; me.ba = ma[24:23]; me.addr = {3'b001, ma[9:0]};
                        me.rd = !mw; me.wr = mw; me.port = mp; me.chk_port = 1;
                        m_q.push_back(me);
                        for (int i = 0; i < TDAL; i++) m_q.push_back(mk(P_NOP));
                    end else begin
                        m_q.push_back(mk(P_NOP));
                    end
                end
                m_exp = m_q.pop_front();
                m_k++;
                if (m_k % TREF == 0) begin
                    if (m_pend) m_ovr = 1;
                    m_pend = 1;
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("cmd_pins", 32'(pins1()), 32'(m_exp.cmd));
            chk("req_ack", 32'(bus.req_ack), 32'(m_exp.ack));
            chk("col_rd", 32'(bus.col_rd), 32'(m_exp.rd));
            chk("col_wr", 32'(bus.col_wr), 32'(m_exp.wr));
            chk("ref_overrun", 32'(bus.ref_overrun), 32'(m_ovr));
            if (m_exp.has_addr) begin
                chk("sdr_ba", 32'(bus.sdr_ba), 32'(m_exp.ba));
                chk("sdr_addr", 32'(bus.sdr_addr), 32'(m_exp.addr));
            end
            if (m_exp.chk_port) chk("col_port", 32'(bus.col_port), 32'(m_exp.port));
        end
    end

    task automatic wait_ack(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.req_ack != 2'b00) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    // ---------------- overrun instance: TREF_CYC=3, TRFC=7, hand-computed timeline
    initial begin
        rst2 = 1'b1; init2 = 1'b0;
        bus2.req_valid = '0; bus2.req_wr = '0; bus2.req_addr0 = '0; bus2.req_addr1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_reset_pins", 32'(pins2()), 32'(P_DESEL));
        chk("ovr_reset_flag", 32'(bus2.ref_overrun), 32'(0));
        rst2 = 1'b0; init2 = 1'b1;
        @(posedge clk); #1;
        chk("ovr_init_edge", 32'(pins2()), 32'(P_DESEL));
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 3) chk("ovr_nop_k3", 32'(pins2()), 32'(P_NOP));
            if (k == 4) chk("ovr_refresh_k4", 32'(pins2()), 32'(P_REF));
            if (k == 8) chk("ovr_clear_k8", 32'(bus2.ref_overrun), 32'(0));
            if (k == 9) chk("ovr_set_k9", 32'(bus2.ref_overrun), 32'(1));
        end
        init2 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_sticky", 32'(bus2.ref_overrun), 32'(1));
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("ovr_cleared_by_reset", 32'(bus2.ref_overrun), 32'(0));
        chk("ovr_reset_pins2", 32'(pins2()), 32'(P_DESEL));
        done2 = 1;
    end

    // ---------------- directed and random stimulus on the main instance
    bit          ok, saw_col;
    logic [1:0]  v;

    initial begin
        rst = 1'b1; init_done = 1'b0;
        bus.req_valid = '0; bus.req_wr = '0; bus.req_addr0 = '0; bus.req_addr1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Init hold
        repeat (50) @(negedge clk);
        chk("init_hold_pins", 32'(pins1()), 32'(P_DESEL));
        init_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_nop", 32'(pins1()), 32'(P_NOP));

        // Single read on port 0
        bus.req_valid = 2'b01; bus.req_wr = 2'b00;
        bus.req_addr0 = {2'b01, 13'h0ABC, 10'h155};
        wait_ack(10, ok);
        bus.req_valid = 2'b00;
        chk("rd_active_pins", 32'(pins1()), 32'(P_ACT));
        chk("rd_active_ba", 32'(bus.sdr_ba), 32'(1));
        chk("rd_active_row", 32'(bus.sdr_addr), 32'h0ABC);
        chk("rd_ack", 32'(bus.req_ack), 32'(2'b01));
        repeat (TRCD) @(negedge clk);
        chk("rd_read_pins", 32'(pins1()), 32'(P_RD));
        chk("rd_read_addr", 32'(bus.sdr_addr), 32'h555);
        chk("rd_col_rd", 32'(bus.col_rd), 32'(1));
        chk("rd_col_port", 32'(bus.col_port), 32'(0));
        for (int i = 0; i < TDAL; i++) begin
            @(negedge clk);
            chk("rd_dal_nop", 32'(pins1()), 32'(P_NOP));
        end

        // Reset while waiting tRCD
        bus.req_valid = 2'b10; bus.req_wr = 2'b10; bus.req_addr1 = 25'h1F0_0ABC;
        wait_ack(10, ok);
        bus.req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_pins", 32'(pins1()), 32'(P_DESEL));
        chk("midreset_col_wr", 32'(bus.col_wr), 32'(0));
        saw_col = 0;
        repeat (10) begin
            @(negedge clk);
            saw_col |= bus.col_rd | bus.col_wr;
        end
        chk("midreset_no_col", 32'(saw_col), 32'(0));

        // Contention and refresh priority from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b11; bus.req_wr = 2'b01;
        wait_ack(10, ok);
        chk("cont_first_ack", 32'(bus.req_ack), 32'(2'b01));
        for (int i = 1; i < 3; i++) begin
            bus.req_addr0 = 25'($urandom); bus.req_addr1 = 25'($urandom);
            repeat (TRCD + TDAL + 1) @(negedge clk);
            chk("cont_spacing_active", 32'(pins1()), 32'(P_ACT));
            chk("cont_alt_ack", 32'(bus.req_ack), (i % 2 == 1) ? 32'(2'b10) : 32'(2'b01));
        end
        repeat (TRCD + TDAL + 1) @(negedge clk);
        chk("refresh_first", 32'(pins1()), 32'(P_REF));
        repeat (TRFC + 1) @(negedge clk);
        chk("post_refresh_active", 32'(pins1()), 32'(P_ACT));
        chk("post_refresh_ack", 32'(bus.req_ack), 32'(2'b10));
        chk("no_overrun", 32'(bus.ref_overrun), 32'(0));

        // Randomized traffic
        v = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            init_done = ($urandom_range(0, 7) != 0);
            for (int p = 0; p < 2; p++) begin
                if (bus.req_ack[p]) v[p] = 1'($urandom_range(0, 1));
                else if (!v[p])     v[p] = ($urandom_range(0, 2) == 0);
            end
            bus.req_valid = v;
            bus.req_wr    = 2'($urandom);
            bus.req_addr0 = 25'($urandom);
            bus.req_addr1 = 25'($urandom);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        if (!done2) chk("ovr_sequence_done", 32'(done2), 32'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
